// File: rtl/cpu_writeback_regfile_pkg.sv
// Shared CPU definitions for the writeback / register file slice.
// Holds the default datapath geometry, the writeback packet layout and
// the result-select helper used by the writeback stage.
package cpu_writeback_regfile_pkg;

    localparam int unsigned CPU_XLEN  = 32;  // datapath width
    localparam int unsigned CPU_NREG  = 32;  // architectural register count
    localparam int unsigned CPU_RADDR = 5;   // register index width, log2(CPU_NREG)

    // Writeback packet as delivered by the memory stage.
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [CPU_RADDR-1:0] reg_dest;
        logic [CPU_XLEN-1:0]  alu_data;
        logic [CPU_XLEN-1:0]  mem_data;
    } wb_pkt_t;

    // Result value carried by a writeback packet.
    function automatic logic [CPU_XLEN-1:0] wb_result(input wb_pkt_t pkt);
        return pkt.mem_to_reg ? pkt.mem_data : pkt.alu_data;
    endfunction

endpackage : cpu_writeback_regfile_pkg

// File: rtl/cpu_writeback_regfile_array.sv
// Register storage with one write port and two bypassed combinational
// read ports.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   we, waddr, wdata      the single write port (register 0 is never written)
//   hold_valid/rd/data    value parked in the writeback holding register
//   rs1_addr/rs2_addr     read addresses
//   rs1_data/rs2_data     read data: 0 for r0 or during reset; otherwise the
//                         youngest value: this cycle's write, then the held
//                         packet, then the array
module cpu_regfile_array
    import cpu_writeback_regfile_pkg::*;
#(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned NREG  = CPU_NREG,
    parameter int unsigned RADDR = CPU_RADDR
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [RADDR-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic             hold_valid,
    input  logic [RADDR-1:0] hold_rd,
    input  logic [XLEN-1:0]  hold_data,
    input  logic [RADDR-1:0] rs1_addr,
    input  logic [RADDR-1:0] rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data
);

    logic [XLEN-1:0] regs [NREG];

    // Storage update; r0 is left at its reset value forever.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1 with write-port and holding-register bypass.
    always_comb begin
        rs1_data = '0;
        if (!reset && (rs1_addr != '0)) begin
            if (we && (waddr == rs1_addr)) begin
                rs1_data = wdata;
            end else if (hold_valid && (hold_rd == rs1_addr)) begin
                rs1_data = hold_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    // Read port 2, same selection as port 1.
    always_comb begin
        rs2_data = '0;
        if (!reset && (rs2_addr != '0)) begin
            if (we && (waddr == rs2_addr)) begin
                rs2_data = wdata;
            end else if (hold_valid && (hold_rd == rs2_addr)) begin
                rs2_data = hold_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

endmodule : cpu_regfile_array

// File: rtl/cpu_writeback_regfile.sv
// Writeback stage register file: arbitrates the single write port between
// late load-miss fills, a one-entry holding register and new writeback
// packets, and keeps a per-register pending (awaiting fill) scoreboard.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   wb_reg_write, wb_mem_to_reg  writeback packet request and result select
//   wb_reg_dest, wb_alu_data,
//   wb_mem_data                  writeback packet destination and candidate values
//   fill_valid/rd/data           load-miss return write (highest priority)
//   pend_set, pend_rd            mark a register as awaiting a fill
//   rs1_addr/rs2_addr,
//   rs1_data/rs2_data            bypassed decode read ports
//   pending                      per-register scoreboard bits (registered)
//   wb_stall                     holding register occupied (registered)
module cpu_writeback_regfile
    import cpu_writeback_regfile_pkg::*;
#(
    parameter int unsigned XLEN  = CPU_XLEN,
    parameter int unsigned NREG  = CPU_NREG,
    parameter int unsigned RADDR = CPU_RADDR
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_reg_write,
    input  logic             wb_mem_to_reg,
    input  logic [RADDR-1:0] wb_reg_dest,
    input  logic [XLEN-1:0]  wb_alu_data,
    input  logic [XLEN-1:0]  wb_mem_data,
    input  logic             fill_valid,
    input  logic [RADDR-1:0] fill_rd,
    input  logic [XLEN-1:0]  fill_data,
    input  logic             pend_set,
    input  logic [RADDR-1:0] pend_rd,
    input  logic [RADDR-1:0] rs1_addr,
    input  logic [RADDR-1:0] rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [NREG-1:0]  pending,
    output logic             wb_stall
);

    wb_pkt_t          wb_pkt_c;
    logic [XLEN-1:0]  wb_data_c;

    logic             hold_valid;
    logic [RADDR-1:0] hold_rd;
    logic [XLEN-1:0]  hold_data;
    logic             hold_valid_nxt_c;
    logic [RADDR-1:0] hold_rd_nxt_c;
    logic [XLEN-1:0]  hold_data_nxt_c;

    logic             we_c;
    logic [RADDR-1:0] waddr_c;
    logic [XLEN-1:0]  wdata_c;

    logic [NREG-1:0]  pending_nxt_c;

    // Bundle the incoming writeback packet and resolve its result value.
    always_comb begin
        wb_pkt_c            = '0;
        wb_pkt_c.reg_write  = wb_reg_write;
        wb_pkt_c.mem_to_reg = wb_mem_to_reg;
        wb_pkt_c.reg_dest   = CPU_RADDR'(wb_reg_dest);
        wb_pkt_c.alu_data   = CPU_XLEN'(wb_alu_data);
        wb_pkt_c.mem_data   = CPU_XLEN'(wb_mem_data);
        wb_data_c           = XLEN'(wb_result(wb_pkt_c));
    end

    // Write-port arbitration and holding-register next state.
    // A new packet arriving while the holder is full is dropped.
    always_comb begin
        we_c             = 1'b0;
        waddr_c          = '0;
        wdata_c          = '0;
        hold_valid_nxt_c = hold_valid;
        hold_rd_nxt_c    = hold_rd;
        hold_data_nxt_c  = hold_data;

        if (fill_valid) begin
            we_c    = 1'b1;
            waddr_c = fill_rd;
            wdata_c = fill_data;
            if (!hold_valid && wb_pkt_c.reg_write) begin
                hold_valid_nxt_c = 1'b1;
                hold_rd_nxt_c    = RADDR'(wb_pkt_c.reg_dest);
                hold_data_nxt_c  = wb_data_c;
            end
        end else if (hold_valid) begin
            we_c             = 1'b1;
            waddr_c          = hold_rd;
            wdata_c          = hold_data;
            hold_valid_nxt_c = 1'b0;
        end else if (wb_pkt_c.reg_write) begin
            we_c    = 1'b1;
            waddr_c = RADDR'(wb_pkt_c.reg_dest);
            wdata_c = wb_data_c;
        end
    end

    // Scoreboard next state: fill clears, pend_set sets (set wins), r0 stays clear.
    always_comb begin
        pending_nxt_c = pending;
        if (fill_valid) begin
            pending_nxt_c[fill_rd] = 1'b0;
        end
        if (pend_set) begin
            pending_nxt_c[pend_rd] = 1'b1;
        end
        pending_nxt_c[0] = 1'b0;
    end

    // Holding register and scoreboard state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
            pending    <= '0;
        end else begin
            hold_valid <= hold_valid_nxt_c;
            hold_rd    <= hold_rd_nxt_c;
            hold_data  <= hold_data_nxt_c;
            pending    <= pending_nxt_c;
        end
    end

    assign wb_stall = hold_valid;

    cpu_regfile_array #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .RADDR (RADDR)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .we         (we_c),
        .waddr      (waddr_c),
        .wdata      (wdata_c),
        .hold_valid (hold_valid),
        .hold_rd    (hold_rd),
        .hold_data  (hold_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data)
    );

endmodule : cpu_writeback_regfile
